// File: rtl/qr_sram_arbiter.sv
// Purpose : shares the image-SRAM read port among finder scan (0), module
//           sampler (1) and codeword reader (2); round-robin with burst lock.
// Latency : req/gnt in cycle N -> sram_raddr in N+1 -> rvalid/rdata in N+1+RD_LAT.
// Backpr. : losers simply see gnt low and keep req/addr stable; one read per cycle.
//
// Ports:
//   clk, srstn              clock, synchronous active-low reset
//   req[2:0], req_lock[2:0] per-requester read request / hold-grant request
//   req_addr0..2            per-requester final SRAM address (no translation)
//   gnt[2:0]                combinational one-hot grant, zero while in reset
//   sram_raddr              registered SRAM read address (0 when idle)
//   sram_rdata              SRAM read data
//   rvalid[2:0]             one-hot tag of the requester owning rdata
//   rdata                   pass-through of sram_rdata
//   busy                    any issued read still in flight
module qr_sram_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          srstn,
  input  logic [2:0]    req,
  input  logic [2:0]    req_lock,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [AW-1:0] req_addr2,
  output logic [2:0]    gnt,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  // ------------------------------------------------------------------
  // Arbitration state
  // ------------------------------------------------------------------
  logic          own_vld;
  logic [1:0]    own_idx;
  logic [1:0]    last_idx;

  logic          lock_hold;
  logic          rr_hit;
  logic [1:0]    rr_idx;
  logic [1:0]    cand;
  logic          win_vld;
  logic [1:0]    win_idx;
  logic [AW-1:0] win_addr;
  logic          win_lock;

  logic [AW-1:0] raddr_q;
  logic [2:0]    tag [0:RD_LAT];

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // The owner keeps the port only while it still asserts both req and
  // req_lock; the cycle it drops either, the port is arbitrated normally.
  assign lock_hold = own_vld & req[own_idx] & req_lock[own_idx];

  // Round-robin search starting one past the last winner, wrapping mod 3.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = 2'd0;
    cand   = last_idx;
    for (int k = 0; k < 3; k++) begin
      cand = next_idx(cand);
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Reset forces the grant low so nothing is issued or tagged in reset.
  assign win_vld = srstn & (lock_hold | rr_hit);
  assign win_idx = lock_hold ? own_idx : rr_idx;

  always_comb begin
    gnt = 3'b000;
    if (win_vld) gnt = 3'(3'b001 << win_idx);
  end

  always_comb begin
    win_addr = '0;
    case (win_idx)
      2'd0:    win_addr = req_addr0;
      2'd1:    win_addr = req_addr1;
      2'd2:    win_addr = req_addr2;
      default: win_addr = '0;
    endcase
  end

  assign win_lock = req_lock[win_idx];

  // ------------------------------------------------------------------
  // Owner / pointer / address registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!srstn) begin
      own_vld  <= 1'b0;
      own_idx  <= 2'd0;
      last_idx <= 2'd2;
      raddr_q  <= '0;
    end else begin
      if (win_vld) begin
        last_idx <= win_idx;
        own_vld  <= win_lock;
        own_idx  <= win_idx;
        raddr_q  <= win_addr;
      end else begin
        own_vld  <= 1'b0;
        raddr_q  <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Read tracking: tag[0] lines up with sram_raddr, tag[RD_LAT] with rdata.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!srstn) begin
      for (int k = 0; k <= RD_LAT; k++) tag[k] <= 3'b000;
    end else begin
      tag[0] <= gnt;
      for (int k = 1; k <= RD_LAT; k++) tag[k] <= tag[k-1];
    end
  end

  logic busy_any;
  always_comb begin
    busy_any = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) busy_any = busy_any | (|tag[k]);
  end

  // Outputs read as their reset values for the whole time srstn is low,
  // including the first reset cycle before the registers have cleared.
  assign sram_raddr = srstn ? raddr_q : '0;
  assign rvalid     = srstn ? tag[RD_LAT] : 3'b000;
  assign busy       = srstn & busy_any;
  assign rdata      = sram_rdata;

endmodule
